// File: rtl/usm_rd_outstanding_throttle.sv
// usm_rd_outstanding_throttle: pass-through USM Avalon-MM port that stalls reads so outstanding read beats never exceed MAX_OUTSTANDING_BEATS; ports: s_* kernel side, m_* CCB side, throttle_en, status outstanding/peak_outstanding/stall_cycles/err
module usm_rd_outstanding_throttle #(
  parameter int ADDR_WIDTH            = 48,
  parameter int DATA_WIDTH            = 512,
  parameter int BURSTCOUNT_WIDTH      = 5,
  parameter int BURSTCOUNT_MAX        = 16,
  parameter int MAX_OUTSTANDING_BEATS = 256,
  parameter int CNT_WIDTH             = $clog2(MAX_OUTSTANDING_BEATS + BURSTCOUNT_MAX) + 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ADDR_WIDTH-1:0]       s_address,
  input  logic                        s_read,
  input  logic                        s_write,
  input  logic [BURSTCOUNT_WIDTH-1:0] s_burstcount,
  input  logic [DATA_WIDTH-1:0]       s_writedata,
  input  logic [DATA_WIDTH/8-1:0]     s_byteenable,
  output logic                        s_waitrequest,
  output logic [DATA_WIDTH-1:0]       s_readdata,
  output logic                        s_readdatavalid,
  output logic [ADDR_WIDTH-1:0]       m_address,
  output logic                        m_read,
  output logic                        m_write,
  output logic [BURSTCOUNT_WIDTH-1:0] m_burstcount,
  output logic [DATA_WIDTH-1:0]       m_writedata,
  output logic [DATA_WIDTH/8-1:0]     m_byteenable,
  input  logic                        m_waitrequest,
  input  logic [DATA_WIDTH-1:0]       m_readdata,
  input  logic                        m_readdatavalid,
  input  logic                        throttle_en,
  output logic [CNT_WIDTH-1:0]        outstanding,
  output logic [CNT_WIDTH-1:0]        peak_outstanding,
  output logic [31:0]                 stall_cycles,
  output logic                        err
);
  localparam logic [CNT_WIDTH:0] MAXB = (CNT_WIDTH+1)'(MAX_OUTSTANDING_BEATS);
  localparam logic [CNT_WIDTH:0] ALL1 = {1'b0, {CNT_WIDTH{1'b1}}};
  localparam logic [BURSTCOUNT_WIDTH-1:0] BMAX = BURSTCOUNT_WIDTH'(BURSTCOUNT_MAX);
  logic [CNT_WIDTH:0] bc, need, sum, dec;
  logic [CNT_WIDTH-1:0] nxt;
  logic fits, gate, rd_acc, under, clamp, bad_bc, proto;
  assign m_address       = s_address;
  assign m_burstcount    = s_burstcount;
  assign m_writedata     = s_writedata;
  assign m_byteenable    = s_byteenable;
  assign s_readdata      = m_readdata;
  assign s_readdatavalid = m_readdatavalid;
  always_comb begin
    bc            = (CNT_WIDTH+1)'(s_burstcount);
    need          = {1'b0, outstanding} + bc;
    fits          = need <= MAXB;
    gate          = s_read & throttle_en & ~fits;
    m_read        = s_read & ~gate;
    m_write       = s_write & ~s_read;
    s_waitrequest = m_waitrequest | gate;
    rd_acc        = m_read & ~m_waitrequest;
    sum           = {1'b0, outstanding} + (rd_acc ? bc : '0);
    dec           = sum - {{CNT_WIDTH{1'b0}}, m_readdatavalid};
    under         = m_readdatavalid & (sum == '0);
    clamp         = ~under & (dec > ALL1);
    nxt           = under ? '0 : clamp ? '1 : dec[CNT_WIDTH-1:0];
    bad_bc        = (s_burstcount == '0) | (s_burstcount > BMAX);
    proto         = (s_read & s_write) | ((s_read | s_write) & bad_bc) | under | clamp;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      outstanding      <= '0;
      peak_outstanding <= '0;
      stall_cycles     <= '0;
      err              <= 1'b0;
    end else begin
      outstanding <= nxt;
      if (nxt > peak_outstanding) peak_outstanding <= nxt;
      if (gate && ~&stall_cycles) stall_cycles <= stall_cycles + 32'd1;
      if (proto) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_usm_rd_outstanding_throttle.sv
// tb_usm_rd_outstanding_throttle: scoreboard bench for the USM read outstanding throttle
module tb_usm_rd_outstanding_throttle;
  localparam int AW = 48, DW = 512, BW = 5, CW = 10;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [AW-1:0] s_address = '0, m_address;
  logic s_read = 1'b0, s_write = 1'b0, s_waitrequest, s_readdatavalid;
  logic [BW-1:0] s_burstcount = '0, m_burstcount;
  logic [DW-1:0] s_writedata = '0, s_readdata, m_writedata, m_readdata = '0;
  logic [DW/8-1:0] s_byteenable = '0, m_byteenable;
  logic m_read, m_write, m_waitrequest = 1'b0, m_readdatavalid = 1'b0, throttle_en = 1'b1, err;
  logic [CW-1:0] outstanding, peak_outstanding;
  logic [31:0] stall_cycles;
  logic [DW-1:0] rq[$];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  usm_rd_outstanding_throttle dut (
    .clk(clk), .reset_n(reset_n), .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_burstcount(s_burstcount), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_burstcount(m_burstcount),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .throttle_en(throttle_en),
    .outstanding(outstanding), .peak_outstanding(peak_outstanding), .stall_cycles(stall_cycles), .err(err)
  );
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset_n = 1'b0; s_read = 0; s_write = 0; s_burstcount = 0; m_readdatavalid = 0; m_waitrequest = 0; throttle_en = 1;
    tick; tick;
    reset_n = 1'b1;
  endtask
  task automatic reads(input int n, input int b);
    for (int i = 0; i < n; i++) begin
      s_read = 1; s_burstcount = BW'(b); s_address = AW'(i * 64);
      tick;
    end
    s_read = 0;
  endtask
  task automatic rand_data(output logic [DW-1:0] d);
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
  endtask
  task automatic drive_rsp(input string tag);
    logic [DW-1:0] d;
    rand_data(d);
    m_readdata = d; m_readdatavalid = 1;
    rq.push_back(d);
    #1;
    chk({tag, "_rvalid"}, s_readdatavalid, 1);
    if (s_readdatavalid) chk({tag, "_rdata"}, s_readdata, rq.pop_front());
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [DW-1:0] wd;
    logic [DW/8-1:0] be;
    int budget;
    do_reset;
    chk("rst_out", outstanding, 0);
    chk("rst_peak", peak_outstanding, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_err", err, 0);
    s_read = 1; s_burstcount = 16; #1;
    chk("first_mread", m_read, 1);
    chk("first_wait", s_waitrequest, 0);
    reads(16, 16);
    chk("full_out", outstanding, 256);
    chk("full_peak", peak_outstanding, 256);
    s_read = 1; s_burstcount = 16; #1;
    chk("gate_wait", s_waitrequest, 1);
    chk("gate_mread", m_read, 0);
    tick; tick; tick;
    chk("stall3", stall_cycles, 3);
    for (int k = 0; k < 16; k++) begin
      drive_rsp("drain");
      chk("drain_gated", m_read, 0);
      tick;
    end
    m_readdatavalid = 0; #1;
    chk("drain_out", outstanding, 240);
    budget = 4;
    while (!m_read && budget > 0) begin tick; budget--; end
    chk("refill_mread", m_read, 1);
    chk("stall19", stall_cycles, 19);
    tick; s_read = 0;
    chk("refill_out", outstanding, 256);
    chk("refill_err", err, 0);
    do_reset;
    reads(6, 16); reads(1, 4);
    chk("at100", outstanding, 100);
    s_read = 1; s_burstcount = 8;
    drive_rsp("same");
    chk("same_mread", m_read, 1);
    tick; s_read = 0; m_readdatavalid = 0;
    chk("same_out", outstanding, 107);
    chk("same_peak", peak_outstanding, 107);
    do_reset;
    throttle_en = 0;
    reads(20, 16);
    chk("nothr_out", outstanding, 320);
    chk("nothr_peak", peak_outstanding, 320);
    chk("nothr_stall", stall_cycles, 0);
    chk("nothr_err", err, 0);
    for (int i = 0; i < 6; i++) begin
      rand_data(wd);
      for (int j = 0; j < DW / 256; j++) be[j*32 +: 32] = $urandom;
      s_write = 1; s_burstcount = 4; s_writedata = wd; s_byteenable = be; m_waitrequest = i[0]; #1;
      chk("wr_wait", s_waitrequest, i[0]);
      chk("wr_mwrite", m_write, 1);
      chk("wr_data", m_writedata, wd);
      chk("wr_be", m_byteenable, be);
      tick;
    end
    s_write = 0; m_waitrequest = 0; throttle_en = 1; #1;
    chk("wr_out", outstanding, 320);
    chk("wr_err", err, 0);
    do_reset;
    s_read = 1; s_burstcount = 0; tick; s_read = 0;
    chk("bc0_err", err, 1);
    chk("bc0_out", outstanding, 0);
    tick; tick;
    chk("bc0_sticky", err, 1);
    do_reset;
    s_read = 1; s_write = 1; s_burstcount = 4; #1;
    chk("rw_mwrite", m_write, 0);
    chk("rw_mread", m_read, 1);
    tick; s_read = 0; s_write = 0;
    chk("rw_err", err, 1);
    chk("rw_out", outstanding, 4);
    do_reset;
    drive_rsp("under");
    tick; m_readdatavalid = 0;
    chk("under_out", outstanding, 0);
    chk("under_err", err, 1);
    do_reset;
    reads(3, 16); reads(1, 2);
    chk("at50", outstanding, 50);
    reset_n = 0; tick; reset_n = 1;
    chk("mid_out", outstanding, 0);
    chk("mid_peak", peak_outstanding, 0);
    chk("mid_stall", stall_cycles, 0);
    chk("mid_err", err, 0);
    chk("sb_empty", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
